// File: rtl/acl2_reading_ascii_formatter_if.sv
// Measurement-in / ASCII-line-out bundle for the ACL2 reading formatter.
interface acl2_reading_ascii_formatter_if #(
  parameter int unsigned parm_drop_cnt_bits = 8
);
  logic [63:0]                   i_data_3axis_temp;
  logic                          i_data_valid;
  logic [215:0]                  o_line_ascii;
  logic                          o_line_valid;
  logic                          o_busy;
  logic [parm_drop_cnt_bits-1:0] o_drop_count;

  modport master (
    output i_data_3axis_temp, i_data_valid,
    input  o_line_ascii, o_line_valid, o_busy, o_drop_count
  );

  modport slave (
    input  i_data_3axis_temp, i_data_valid,
    output o_line_ascii, o_line_valid, o_busy, o_drop_count
  );
endinterface

// File: rtl/acl2_reading_ascii_formatter.sv
// Converts the ACL2 X/Y/Z/Temperature readings into a 27-char ASCII line
// ("X+0123 Y-0045 Z+1002 T+0210") using a sequential double-dabble engine.
module acl2_reading_ascii_formatter #(
  parameter logic [7:0]  parm_sep_char      = 8'h20,
  parameter int unsigned parm_drop_cnt_bits = 8
) (
  input logic                          i_clk_20mhz,
  input logic                          i_rst_20mhz,
  acl2_reading_ascii_formatter_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_STORE,
    ST_DONE
  } state_t;

  state_t                        state;
  logic [11:0]                   cap_val [0:3];
  logic [1:0]                    idx;
  logic                          sign_q;
  logic [11:0]                   mag_q;
  logic [15:0]                   bcd_q;
  logic [3:0]                    iter_q;
  logic [47:0]                   field_q [0:3];
  logic [215:0]                  line_q;
  logic                          line_valid_q;
  logic                          busy_q;
  logic [parm_drop_cnt_bits-1:0] drop_q;

  logic [11:0] raw_val;
  logic [11:0] raw_mag;
  logic [15:0] bcd_adj;
  logic [15:0] bcd_shift;
  logic [7:0]  letter;

  // Select the current reading, take its magnitude and prepare one double-dabble step
  always_comb begin
    raw_val = cap_val[idx];
    raw_mag = raw_val[11] ? (~raw_val + 12'd1) : raw_val;
    bcd_adj = bcd_q;
    for (int unsigned i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
    end
    bcd_shift = (bcd_adj << 1) | {15'b0, mag_q[11]};
    case (idx)
      2'd0:    letter = 8'h58;
      2'd1:    letter = 8'h59;
      2'd2:    letter = 8'h5A;
      default: letter = 8'h54;
    endcase
  end

  // Conversion sequencer, drop counter and registered outputs.
  // busy_q stays high through the line_valid cycle, so a sample arriving in
  // that cycle is counted as a drop rather than accepted.
  always_ff @(posedge i_clk_20mhz) begin
    if (i_rst_20mhz) begin
      state        <= ST_IDLE;
      idx          <= '0;
      sign_q       <= 1'b0;
      mag_q        <= '0;
      bcd_q        <= '0;
      iter_q       <= '0;
      line_q       <= '0;
      line_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      drop_q       <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        cap_val[i] <= '0;
        field_q[i] <= '0;
      end
    end else begin
      line_valid_q <= 1'b0;
      if (bus.i_data_valid && busy_q && (drop_q != '1)) begin
        drop_q <= drop_q + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (bus.i_data_valid && !busy_q) begin
            cap_val[0] <= {bus.i_data_3axis_temp[51:48], bus.i_data_3axis_temp[63:56]};
            cap_val[1] <= {bus.i_data_3axis_temp[35:32], bus.i_data_3axis_temp[47:40]};
            cap_val[2] <= {bus.i_data_3axis_temp[19:16], bus.i_data_3axis_temp[31:24]};
            cap_val[3] <= {bus.i_data_3axis_temp[3:0],   bus.i_data_3axis_temp[15:8]};
            idx        <= '0;
            busy_q     <= 1'b1;
            state      <= ST_LOAD;
          end else begin
            busy_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          sign_q <= raw_val[11];
          mag_q  <= raw_mag;
          bcd_q  <= '0;
          iter_q <= '0;
          state  <= ST_SHIFT;
        end
        ST_SHIFT: begin
          bcd_q  <= bcd_shift;
          mag_q  <= {mag_q[10:0], 1'b0};
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'd11) begin
            state <= ST_STORE;
          end
        end
        ST_STORE: begin
          field_q[idx] <= {letter, (sign_q ? 8'h2D : 8'h2B),
                           4'h3, bcd_q[15:12], 4'h3, bcd_q[11:8],
                           4'h3, bcd_q[7:4],   4'h3, bcd_q[3:0]};
          if (idx == 2'd3) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 2'd1;
            state <= ST_LOAD;
          end
        end
        ST_DONE: begin
          line_q       <= {field_q[0], parm_sep_char, field_q[1], parm_sep_char,
                           field_q[2], parm_sep_char, field_q[3]};
          line_valid_q <= 1'b1;
          state        <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_line_ascii = line_q;
  assign bus.o_line_valid = line_valid_q;
  assign bus.o_busy       = busy_q;
  assign bus.o_drop_count = drop_q;

endmodule

// File: tb/tb_acl2_reading_ascii_formatter.sv
// Scoreboard bench for the ACL2 reading ASCII formatter.
module tb_acl2_reading_ascii_formatter;

  localparam int unsigned DROP_BITS = 8;
  localparam int unsigned LATENCY   = 57;

  localparam logic [63:0]  D_NOM = 64'h7B00_D3FF_EA03_D200;
  localparam logic [215:0] L_NOM = "X+0123 Y-0045 Z+1002 T+0210";
  localparam logic [63:0]  D_EXT = 64'h00F8_FF07_0000_FF0F;
  localparam logic [215:0] L_EXT = "X-2048 Y+2047 Z+0000 T-0001";
  localparam logic [63:0]  D_NIB = 64'h1035_0000_0000_0000;
  localparam logic [215:0] L_NIB = "X+1296 Y+0000 Z+0000 T+0000";
  localparam logic [63:0]  D_OTH = 64'h0100_0200_0300_0400;

  logic clk = 1'b0;
  logic rst;
  always #25 clk = ~clk;

  acl2_reading_ascii_formatter_if #(.parm_drop_cnt_bits(DROP_BITS)) bus ();

  acl2_reading_ascii_formatter #(
    .parm_sep_char     (8'h20),
    .parm_drop_cnt_bits(DROP_BITS)
  ) u_dut (
    .i_clk_20mhz(clk),
    .i_rst_20mhz(rst),
    .bus        (bus.slave)
  );

  typedef struct {
    logic [215:0] line;
    int unsigned  due;
  } exp_t;

  exp_t        sb[$];
  int unsigned cyc = 0;
  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  logic        prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input logic [215:0] act, input logic [215:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a line is presented
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_valid = 1'b0;
    end else begin
      if (bus.o_line_valid) begin
        check_val("line_valid_single_cycle", {215'b0, prev_valid}, 216'd0);
        if (sb.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_line: got %0h expected none", bus.o_line_ascii);
        end else begin
          e = sb.pop_front();
          check_val("line_ascii", bus.o_line_ascii, e.line);
          check_val("line_latency", 216'(cyc), 216'(e.due));
        end
      end
      prev_valid = bus.o_line_valid;
    end
  end

  task automatic send(input logic [63:0] d, input bit sync, output int unsigned e0);
    if (sync) @(negedge clk);
    bus.i_data_3axis_temp = d;
    bus.i_data_valid      = 1'b1;
    @(posedge clk);
    #1;
    e0 = cyc;
    bus.i_data_valid = 1'b0;
  endtask

  task automatic send_exp(input logic [63:0] d, input logic [215:0] line, input bit sync);
    int unsigned e0;
    exp_t        e;
    send(d, sync, e0);
    e.line = line;
    e.due  = e0 + LATENCY;
    sb.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (!bus.o_busy && sb.size() == 0) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL %s_timeout: got busy=%0b pending=%0d expected idle", name, bus.o_busy, sb.size());
  endtask

  task automatic wait_line(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.o_line_valid) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL %s_timeout: got no line_valid expected one", name);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned e0;
    exp_t        e;
    rst = 1'b1;
    bus.i_data_valid      = 1'b0;
    bus.i_data_3axis_temp = '0;
    repeat (3) @(negedge clk);
    check_val("rst_line_ascii", bus.o_line_ascii, 216'd0);
    check_val("rst_line_valid", {215'b0, bus.o_line_valid}, 216'd0);
    check_val("rst_busy", {215'b0, bus.o_busy}, 216'd0);
    check_val("rst_drop_count", {208'b0, bus.o_drop_count}, 216'd0);
    rst = 1'b0;

    // Nominal conversion
    send_exp(D_NOM, L_NOM, 1'b1);
    check_val("busy_after_capture", {215'b0, bus.o_busy}, 216'd1);
    wait_idle("nominal");

    // Extremes and ignored upper nibble
    send_exp(D_EXT, L_EXT, 1'b1);
    wait_idle("extremes");
    send_exp(D_NIB, L_NIB, 1'b1);
    wait_idle("upper_nibble");
    check_val("drop_count_none", {208'b0, bus.o_drop_count}, 216'd0);

    // Overrun: second sample 20 clocks into the conversion is dropped
    send_exp(D_NOM, L_NOM, 1'b1);
    repeat (20) @(posedge clk);
    send(D_OTH, 1'b1, e0);
    wait_idle("overrun");
    check_val("drop_count_overrun", {208'b0, bus.o_drop_count}, 216'd1);

    // Back-to-back: sample in the cycle after line_valid is accepted
    send_exp(D_NIB, L_NIB, 1'b1);
    wait_line("b2b_first");
    send_exp(D_EXT, L_EXT, 1'b1);
    check_val("drop_count_b2b", {208'b0, bus.o_drop_count}, 216'd1);
    // Sample coincident with the line_valid cycle is dropped
    wait_line("b2b_second");
    send(D_OTH, 1'b0, e0);
    wait_idle("coincident");
    check_val("drop_count_coincident", {208'b0, bus.o_drop_count}, 216'd2);

    // Reset mid-conversion: no line, outputs cleared, next sample converts
    send(D_EXT, 1'b1, e0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_busy", {215'b0, bus.o_busy}, 216'd0);
    check_val("midrst_line_valid", {215'b0, bus.o_line_valid}, 216'd0);
    check_val("midrst_line_ascii", bus.o_line_ascii, 216'd0);
    check_val("midrst_drop_count", {208'b0, bus.o_drop_count}, 216'd0);
    rst = 1'b0;
    send_exp(D_NOM, L_NOM, 1'b0);
    wait_idle("after_reset");

    // Saturation: valid held high for 300 cycles; accepts every 59 cycles
    @(negedge clk);
    bus.i_data_3axis_temp = D_NOM;
    bus.i_data_valid      = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        for (int k = 0; k < 6; k++) begin
          e.line = L_NOM;
          e.due  = cyc + 59 * k + LATENCY;
          sb.push_back(e);
        end
      end
    end
    bus.i_data_valid = 1'b0;
    wait_idle("saturation");
    check_val("drop_count_saturated", {208'b0, bus.o_drop_count}, 216'd255);

    repeat (5) @(negedge clk);
    check_val("scoreboard_drained", 216'(sb.size()), 216'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
